// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM input PIO: register word addresses and edge-type codes.
package pio_pkg;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One-bit debounce filter: output follows input only after DEBOUNCE consecutive
// cycles of disagreement. DEBOUNCE=0 makes it a plain wire.
module pio_debounce_bit #(
    parameter int unsigned DEBOUNCE = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign q = d;
        end else begin : g_filter
            localparam int unsigned CW = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_q;
            logic          stable_q;

            // Any cycle of agreement restarts the count, so short glitches are dropped.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (d == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_q <= d;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign q = stable_q;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM read-only input PIO with 2-FF synchroniser, optional debounce,
// per-bit edge capture (write-1-to-clear), interrupt mask and level IRQ.
module avalon_pio_in_edge
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEBOUNCE  = 0,
    parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      readdata_q;
    logic [31:0]      read_mux;
    logic             wr_en;
    logic             unused_writedata;

    // Bits of writedata above WIDTH have no destination.
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_debounce
            pio_debounce_bit #(
                .DEBOUNCE(DEBOUNCE)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .d      (sync2_q[i]),
                .q      (stable[i])
            );
        end
    endgenerate

    assign rise = stable & ~prev_q;
    assign fall = ~stable & prev_q;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            evt = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            evt = rise | fall;
        end else begin
            evt = rise;
        end
    end

    assign wr_en      = chipselect & ~write_n;
    assign clear_bits = (wr_en && address == PIO_EDGE) ? writedata[WIDTH-1:0] : '0;

    // A new edge is OR-ed in after the clear, so it wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            prev_q         <= stable;
            edge_capture_q <= (edge_capture_q & ~clear_bits) | evt;
            if (wr_en && address == PIO_MASK) begin
                irq_mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        read_mux = '0;
        unique case (address)
            PIO_DATA: read_mux[WIDTH-1:0] = stable;
            PIO_MASK: read_mux[WIDTH-1:0] = irq_mask_q;
            PIO_EDGE: read_mux[WIDTH-1:0] = edge_capture_q;
            default:  read_mux = '0;
        endcase
    end

    // Read data is refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= read_mux;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for avalon_pio_in_edge: five configurations share one bus and one input
// vector; each is checked against a behavioural model and directed expectations.
module tb_avalon_pio_in_edge;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [15:0] in_port = 16'h0;
    logic [31:0] rd [NI];
    logic        irq_o [NI];

    int checks = 0;
    int failures = 0;

    // Model state: input delay line, filtered value, previous value, registers.
    logic [31:0] m_s1 [NI];
    logic [31:0] m_s2 [NI];
    logic [31:0] m_filt [NI];
    logic [31:0] m_prev [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] m_edge [NI];
    logic [31:0] m_rd [NI];
    logic [31:0] m_hist [NI][8];

    always #5 clk = ~clk;

    avalon_pio_in_edge #(.WIDTH(16), .DEBOUNCE(0), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
        .in_port(in_port), .irq(irq_o[0]));
    avalon_pio_in_edge #(.WIDTH(16), .DEBOUNCE(4), .EDGE_TYPE(0)) dut_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
        .in_port(in_port), .irq(irq_o[1]));
    avalon_pio_in_edge #(.WIDTH(16), .DEBOUNCE(0), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
        .in_port(in_port), .irq(irq_o[2]));
    avalon_pio_in_edge #(.WIDTH(16), .DEBOUNCE(0), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[3]),
        .in_port(in_port), .irq(irq_o[3]));
    avalon_pio_in_edge #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(0)) dut_w8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[4]),
        .in_port(in_port[7:0]), .irq(irq_o[4]));

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_s1[k] = '0; m_s2[k] = '0; m_filt[k] = '0; m_prev[k] = '0;
            m_mask[k] = '0; m_edge[k] = '0; m_rd[k] = '0;
            for (int j = 0; j < 8; j++) m_hist[k][j] = '0;
        end
    endtask

    // One clock edge of instance k, computed from the register-level rules.
    task automatic model_step(input int k);
        int unsigned n, et, w;
        logic [31:0] wm, stab, rise, fall, ev, clr;
        bit wr, agree;
        n  = (k == 1) ? 4 : 0;
        et = (k == 2) ? 1 : (k == 3) ? 2 : 0;
        w  = (k == 4) ? 8 : 16;
        wm = (32'h1 << w) - 32'h1;
        stab = (n == 0) ? m_s2[k] : m_filt[k];
        rise = stab & ~m_prev[k];
        fall = ~stab & m_prev[k];
        ev = ((et == 0) ? rise : (et == 1) ? fall : (rise | fall)) & wm;
        case (address)
            2'd0: m_rd[k] = stab;
            2'd2: m_rd[k] = m_mask[k];
            2'd3: m_rd[k] = m_edge[k];
            default: m_rd[k] = 32'h0;
        endcase
        wr = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
        m_edge[k] = (m_edge[k] & ~clr) | ev;
        if (wr && address == 2'd2) m_mask[k] = writedata & wm;
        m_prev[k] = stab;
        if (n > 0) begin
            for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = m_s2[k];
            // Accept a bit once the last n synchronised samples all disagree with it.
            for (int b = 0; b < 32; b++) begin
                agree = 1'b1;
                for (int j = 0; j < int'(n); j++)
                    if (m_hist[k][j][b] == m_filt[k][b]) agree = 1'b0;
                if (agree) m_filt[k][b] = ~m_filt[k][b];
            end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = {16'h0, in_port} & wm;
    endtask

    // Advance one full cycle: model follows the rising edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else for (int k = 0; k < NI; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 16'hA5A5; address = 2'd0;
        model_reset();
        repeat (3) cycle();
        if (rd[0] !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd[0]); end
        checks++;
        if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o[0]); end
        checks++;
        reset_n = 1'b1;
        repeat (2) cycle();
        if (rd[0] !== 32'h0) begin failures++; $display("FAIL rd_edge2 got=%h exp=0", rd[0]); end
        checks++;
        cycle();
        if (rd[0] !== 32'h0000A5A5) begin
            failures++; $display("FAIL rd_edge3 got=%h exp=0000a5a5", rd[0]);
        end
        checks++;
        address = 2'd3;
        cycle();
        if (rd[0] !== 32'h0000A5A5) begin
            failures++; $display("FAIL reset_edgecap got=%h exp=0000a5a5", rd[0]);
        end
        checks++;
        if (rd[4] !== 32'h000000A5) begin
            failures++; $display("FAIL w8_edgecap got=%h exp=000000a5", rd[4]);
        end
        checks++;
        if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL masked_irq got=%b exp=0", irq_o[0]); end
        checks++;
    endtask

    task automatic test_mask_w1c();
        in_port = 16'h0;
        repeat (4) cycle();
        bus_write(2'd3, 32'hFFFF);
        bus_write(2'd2, 32'h0004);
        address = 2'd3;
        in_port = 16'h0004;
        repeat (2) cycle();
        if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq_o[0]); end
        checks++;
        cycle();
        if (irq_o[0] !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq_o[0]); end
        checks++;
        cycle();
        if (rd[0] !== 32'h4) begin failures++; $display("FAIL edge_bit2 got=%h exp=4", rd[0]); end
        checks++;
        bus_write(2'd3, 32'h0004);
        if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq_o[0]); end
        checks++;
        address = 2'd3;
        cycle();
        if (rd[0] !== 32'h0) begin failures++; $display("FAIL edge_cleared got=%h exp=0", rd[0]); end
        checks++;
    endtask

    task automatic test_simul_clear();
        in_port = 16'h000C;
        repeat (4) cycle();
        in_port = 16'h0004;
        repeat (4) cycle();
        if (rd[0] !== 32'h8) begin failures++; $display("FAIL pre_simul got=%h exp=8", rd[0]); end
        checks++;
        in_port = 16'h000C;
        repeat (2) cycle();
        // This write lands on the same edge as the new rising event on bit 3.
        bus_write(2'd3, 32'h0008);
        cycle();
        if (rd[0] !== 32'h8) begin failures++; $display("FAIL simul_set_wins got=%h exp=8", rd[0]); end
        checks++;
        bus_write(2'd3, 32'h0008);
        cycle();
        if (rd[0] !== 32'h0) begin failures++; $display("FAIL plain_clear got=%h exp=0", rd[0]); end
        checks++;
    endtask

    task automatic test_debounce();
        bus_write(2'd3, 32'hFFFF);
        address = 2'd0;
        repeat (6) cycle();
        in_port = 16'h000D;
        repeat (3) cycle();
        in_port = 16'h000C;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (rd[1][0] !== 1'b0) begin
                failures++; $display("FAIL short_pulse cyc=%0d got=%b exp=0", i, rd[1][0]);
            end
            checks++;
        end
        address = 2'd3;
        repeat (2) cycle();
        if (rd[1][0] !== 1'b0) begin failures++; $display("FAIL pulse_edge got=%b exp=0", rd[1][0]); end
        checks++;
        address = 2'd0;
        in_port = 16'h000D;
        repeat (6) cycle();
        if (rd[1][0] !== 1'b0) begin failures++; $display("FAIL deb_early got=%b exp=0", rd[1][0]); end
        checks++;
        cycle();
        if (rd[1][0] !== 1'b1) begin failures++; $display("FAIL deb_accept got=%b exp=1", rd[1][0]); end
        checks++;
        address = 2'd3;
        repeat (2) cycle();
        if (rd[1][0] !== 1'b1) begin failures++; $display("FAIL deb_edge got=%b exp=1", rd[1][0]); end
        checks++;
    endtask

    task automatic test_edge_modes();
        bus_write(2'd3, 32'hFFFF);
        address = 2'd3;
        in_port = 16'h000F;
        repeat (5) cycle();
        if (rd[2][1] !== 1'b0) begin failures++; $display("FAIL fall_on_rise got=%b exp=0", rd[2][1]); end
        checks++;
        if (rd[3][1] !== 1'b1) begin failures++; $display("FAIL any_on_rise got=%b exp=1", rd[3][1]); end
        checks++;
        bus_write(2'd3, 32'h0002);
        address = 2'd3;
        cycle();
        if (rd[3][1] !== 1'b0) begin failures++; $display("FAIL any_cleared got=%b exp=0", rd[3][1]); end
        checks++;
        in_port = 16'h000D;
        repeat (5) cycle();
        if (rd[2][1] !== 1'b1) begin failures++; $display("FAIL fall_on_fall got=%b exp=1", rd[2][1]); end
        checks++;
        if (rd[3][1] !== 1'b1) begin failures++; $display("FAIL any_on_fall got=%b exp=1", rd[3][1]); end
        checks++;
    endtask

    task automatic test_width();
        address = 2'd1;
        repeat (2) cycle();
        if (rd[4] !== 32'h0) begin failures++; $display("FAIL addr1_w8 got=%h exp=0", rd[4]); end
        checks++;
        if (rd[0] !== 32'h0) begin failures++; $display("FAIL addr1_w16 got=%h exp=0", rd[0]); end
        checks++;
        bus_write(2'd0, 32'hFFFFFFFF);
        bus_write(2'd1, 32'hFFFFFFFF);
        address = 2'd0;
        repeat (2) cycle();
        if (rd[4] !== 32'h0000000D) begin failures++; $display("FAIL data_w8 got=%h exp=0000000d", rd[4]); end
        checks++;
        bus_write(2'd2, 32'hFFFFFFFF);
        address = 2'd2;
        repeat (2) cycle();
        if (rd[4] !== 32'h000000FF) begin failures++; $display("FAIL mask_w8 got=%h exp=000000ff", rd[4]); end
        checks++;
        if (rd[0] !== 32'h0000FFFF) begin failures++; $display("FAIL mask_w16 got=%h exp=0000ffff", rd[0]); end
        checks++;
    endtask

    task automatic test_random();
        logic exp_irq;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 16'(32'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) in_port = 16'($urandom);
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                chipselect = 1'b1; write_n = 1'($urandom_range(0, 1)); writedata = $urandom;
            end else begin
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
            end
            cycle();
            for (int k = 0; k < NI; k++) begin
                if (rd[k] !== m_rd[k]) begin
                    failures++; $display("FAIL rand_rd inst=%0d cyc=%0d got=%h exp=%h", k, c, rd[k], m_rd[k]);
                end
                checks++;
                exp_irq = |(m_edge[k] & m_mask[k]);
                if (irq_o[k] !== exp_irq) begin
                    failures++; $display("FAIL rand_irq inst=%0d cyc=%0d got=%b exp=%b", k, c, irq_o[k], exp_irq);
                end
                checks++;
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_async_reset();
        bus_write(2'd2, 32'hFFFF);
        address = 2'd3;
        in_port = 16'h5A5A;
        repeat (6) cycle();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            if (rd[k] !== 32'h0) begin failures++; $display("FAIL async_rd inst=%0d got=%h exp=0", k, rd[k]); end
            checks++;
            if (irq_o[k] !== 1'b0) begin failures++; $display("FAIL async_irq inst=%0d got=%b exp=0", k, irq_o[k]); end
            checks++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        repeat (3) cycle();
        if (rd[1][1] !== 1'b0) begin failures++; $display("FAIL deb_after_reset got=%b exp=0", rd[1][1]); end
        checks++;
        if (rd[0] !== 32'h00005A5A) begin failures++; $display("FAIL data_after_reset got=%h exp=00005a5a", rd[0]); end
        checks++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mask_w1c();
        test_simul_clear();
        test_debounce();
        test_edge_modes();
        test_width();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_pio_in_edge.md
Name: avalon_pio_in_edge

Overview:
- Parametrised Avalon-MM slave input PIO. It is the next generation of the team's read-only switch/button input ports.
- Adds a 2-FF synchroniser, an optional per-bit debounce filter, a per-bit edge-capture register, an interrupt mask and a level IRQ.
- Sits between board-level pushbuttons/switches and the Nios II data master. The IRQ output goes to the processor interrupt controller.

Parameters:
- WIDTH, 16, number of input bits (1..32).
- DEBOUNCE, 0, consecutive stable cycles a bit needs before it is accepted. 0 bypasses the filter.
- EDGE_TYPE, 0, edge that sets the capture bit: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: reset is asynchronous, active-low on reset_n; clock is clk. Reset clears every flop to 0: sync1, sync2, stable, prev, debounce counters, irq_mask, edge_capture and readdata. irq therefore reads 0 during reset.
- Synchroniser:
  - sync1 <= in_port; sync2 <= sync1.
  - No logic sits between the two stages.
- Debounce, DEBOUNCE=0: stable = sync2, combinational passthrough.
- Debounce, DEBOUNCE>0, per bit:
  - Counter width is clog2(DEBOUNCE+1).
  - If sync2[i] == stable[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: stable[i] <= sync2[i]; cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse shorter than DEBOUNCE cycles never reaches stable.
  - Added latency is exactly DEBOUNCE cycles.
- Edge detect:
  - prev <= stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev; evt is selected by EDGE_TYPE.
- Register map, read (readdata updated every clock, independent of chipselect, 1-cycle latency):
  - 0: data, stable zero-extended to 32 bits.
  - 1: reads 0.
  - 2: irq_mask.
  - 3: edge_capture.
  - Bits above WIDTH always read 0.
- Register map, write (chipselect && !write_n):
  - 0: ignored.
  - 1: ignored.
  - 2: irq_mask <= writedata[WIDTH-1:0].
  - 3: write-1-to-clear: edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | evt.
- Capture: when not clearing, edge_capture <= edge_capture | evt. If a new edge and a clear hit the same bit in the same cycle, the set wins.
- irq = |(edge_capture & irq_mask). It is driven combinationally from flops, so it adds no cycle.
- Latency, DEBOUNCE=0: in_port changes with setup before edge k.
  - Edge k+1: value is in sync2.
  - Edge k+2: readdata (address 0 held) shows the new value, the edge_capture bit is set, and irq rises if the bit is unmasked.
  - DEBOUNCE>0 adds DEBOUNCE edges to all of these.
- Input high at reset release: it is seen as a 0->1 transition and sets edge_capture when EDGE_TYPE is 0 or 2. This is intentional; software clears edge_capture at init.
- Reset asserted mid-debounce or mid-capture: all state returns to 0 immediately. Any partial count is lost.

Decomposition:
- Shared package pio_pkg holds:
  - Register address constants: PIO_DATA=0, PIO_MASK=2, PIO_EDGE=3.
  - Edge-type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, pio_debounce_bit:
  - Parameter: DEBOUNCE.
  - Ports: clk, reset_n, d, q.
  - Instantiated WIDTH times by a generate loop.
  - With DEBOUNCE=0 it reduces to a wire.

Test Plan:
- Reset and basic read:
  - Stimulus: reset_n low with in_port=16'hA5A5, then release, hold address=0, no writes.
  - Required response: readdata=0 during reset; 32'h0000A5A5 at the 3rd edge after release.
  - Required response: edge_capture=16'hA5A5 (EDGE_TYPE=0).
  - Required response: irq stays 0 because the mask is 0.
- Masked IRQ and W1C:
  - Stimulus: clear edge (write 0xFFFF to address 3), write irq_mask=16'h0004, then drive in_port[2] 0->1.
  - Required response: irq=1 two edges later; address 3 reads 0x0004.
  - Stimulus: write 0x0004 to address 3.
  - Required response: irq=0 the next cycle.
- Simultaneous clear and edge:
  - Stimulus: W1C of bit 3 issued in the same cycle that a new rising evt on bit 3 arrives.
  - Required response: bit 3 stays 1.
- Debounce (DEBOUNCE=4):
  - Stimulus: a 3-cycle high pulse on in_port[0].
  - Required response: data bit 0 and edge bit 0 stay 0.
  - Stimulus: a 5-cycle high level on in_port[0].
  - Required response: the bit is accepted 2+4 edges after the change.
- Edge modes:
  - Stimulus: EDGE_TYPE=1 with a 1->0 transition on bit 1.
  - Required response: edge bit 1 is set; a rising transition does not set it.
  - Stimulus: EDGE_TYPE=2.
  - Required response: both transitions set the bit.
- Width and unused addresses (WIDTH=8):
  - Stimulus: read address 1; write 32'hFFFFFFFF to addresses 0, 1 and 2.
  - Required response: address 1 reads 0.
  - Required response: data is unchanged by the writes to addresses 0 and 1.
  - Required response: address 2 then reads 32'h000000FF.
